kong_game_sequencer: RTL and testbench
======================================

Name: kong_game_sequencer

Overview:
- Frame-level game-flow controller for the Kong player datapath: title, play, death, respawn, level clear and game over.
- Sequences the player-logic block by gating its per-frame update and driving its active-low reset for respawn.
- Tracks lives and the level number.
- Sits between the keypad/collision matrix and the player-logic instance; all decisions are taken on startOfFrame.

Parameters:
- START_LIVES, 3: lives loaded on game start (1..3).
- NUM_LEVELS, 4: level counter wraps to 0 after NUM_LEVELS-1.
- DEATH_FRAMES, 60: frames spent in DYING.
- CLEAR_FRAMES, 90: frames spent in LEVEL_CLEAR.
- OVER_FRAMES, 180: frames in GAME_OVER before auto-return to TITLE.
- FALL_Y, 470: player_y strictly greater than this counts as a fall death.
- BLINK_LOG2, 3: show_player toggles every 2^BLINK_LOG2 frames while DYING.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- ask_start  in  1  keypad start/jump key, level-sensitive.
- collision_enemy  in  1  player/enemy pixel collision, any cycle.
- collision_goal  in  1  player/goal pixel collision, any cycle.
- player_y  in  11  signed, player top-left Y (location type).
- player_frame_en  out  1  startOfFrame forwarded to player logic only while PLAYING.
- player_resetN  out  1  active-low reset for player logic.
- show_player  out  1  player sprite draw enable.
- game_state  out  3  TITLE=0, PLAYING=1, DYING=2, RESPAWN=3, LEVEL_CLEAR=4, GAME_OVER=5.
- lives  out  2  remaining lives.
- level  out  2  current level index.

Behaviour:
- Synchronous reset values: state TITLE, lives=0, level=0, frame counter=0, all latches 0, player_resetN=0, show_player=0.
- Reset asserted mid-game overrides any state on the next edge.
- In-frame latches (enemy_hit, goal_hit, start_req):
  - On non-SOF cycles: latch <= latch | input.
  - On the SOF cycle: latch <= input. The current cycle's input counts toward the next frame and is never lost.
- All state, counter, lives and level updates occur only on SOF cycles, using latch values from the previous frame.
- fall = player_y > FALL_Y, signed compare, sampled on the SOF cycle.
- player_frame_en = startOfFrame & (state==PLAYING). Combinational, same cycle, based on current state.
- player_resetN is registered: 0 in TITLE, RESPAWN and GAME_OVER; 1 otherwise.
- show_player:
  - 0 in TITLE and GAME_OVER.
  - In DYING, equals bit BLINK_LOG2 of the frame counter, inverted, so it starts visible.
  - 1 elsewhere.
- Frame counter: 8-bit, cleared on every state change, incremented each SOF while in a timed state. Timed-state exit occurs on the SOF where counter==N-1, i.e. exactly N frames.
- TITLE: start_req at SOF -> RESPAWN; lives<=START_LIVES, level<=0.
- PLAYING, priority order at SOF:
  1. enemy_hit or fall -> DYING; lives<=lives-1, saturating at 0.
  2. Else goal_hit -> LEVEL_CLEAR.
  3. Death beats goal when both occur in the same frame.
- DYING: after DEATH_FRAMES -> GAME_OVER if lives==0, else RESPAWN.
- RESPAWN: exactly one frame; player_resetN held low for that whole frame; next SOF -> PLAYING.
- LEVEL_CLEAR: after CLEAR_FRAMES -> RESPAWN; level<=(level==NUM_LEVELS-1)?0:level+1.
- GAME_OVER: -> TITLE after OVER_FRAMES, or earlier at any SOF with start_req, whichever comes first.
- Latches in non-PLAYING states are still maintained but ignored, except start_req in TITLE and GAME_OVER.

Optional Feature:
- Macro: KONG_GOD_MODE_EN.
- When defined:
  - enemy_hit is ignored in PLAYING.
  - fall, instead of killing, sends the sequencer to RESPAWN with no life lost.
  - lives never decrements.
- When undefined: behaviour exactly as above.

Test Plan:
- Reset, then ask_start pulse mid-frame -> next SOF game_state=3, lives=3, player_resetN=0; following SOF game_state=1, player_resetN=1; player_frame_en pulses on every later SOF.
- In PLAYING, collision_enemy 1 cycle mid-frame -> next SOF game_state=2, lives=2, player_frame_en stays 0; show_player=1 for frames 0-7, 0 for 8-15; after 60 SOFs game_state=3.
- collision_enemy and collision_goal in the same frame -> game_state=2 (death wins), level unchanged.
- lives=1, player_y=471 at SOF -> DYING, lives=0; after 60 frames GAME_OVER; ask_start at frame 10 -> TITLE at that SOF.
- level=3, collision_goal -> LEVEL_CLEAR; after 90 frames level=0, game_state=3.
- collision_enemy asserted exactly on the SOF cycle -> ignored for that decision, death taken at the following SOF.

Source files
------------

// File: rtl/kong_game_sequencer.sv
// Kong game-flow sequencer: title, play, death, respawn, level clear and game over.
// Optional build macro KONG_GOD_MODE_EN: enemies are harmless, falls respawn without losing a life.
module kong_game_sequencer #(
   parameter int START_LIVES  = 3,
   parameter int NUM_LEVELS   = 4,
   parameter int DEATH_FRAMES = 60,
   parameter int CLEAR_FRAMES = 90,
   parameter int OVER_FRAMES  = 180,
   parameter int FALL_Y       = 470,
   parameter int BLINK_LOG2   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               ask_start,
   input  logic               collision_enemy,
   input  logic               collision_goal,
   input  logic signed [10:0] player_y,
   output logic               player_frame_en,
   output logic               player_resetN,
   output logic               show_player,
   output logic [2:0]         game_state,
   output logic [1:0]         lives,
   output logic [1:0]         level
);

   typedef enum logic [2:0] {
      TITLE       = 3'd0,
      PLAYING     = 3'd1,
      DYING       = 3'd2,
      RESPAWN     = 3'd3,
      LEVEL_CLEAR = 3'd4,
      GAME_OVER   = 3'd5
   } state_t;

   localparam logic signed [10:0] FALL_LIMIT = 11'(FALL_Y);

   state_t     state, state_nxt;
   logic [7:0] frame_cnt, cnt_nxt;
   logic [1:0] lives_nxt, level_nxt;
   logic       enemy_hit, goal_hit, start_req;
   logic       fall;

   assign fall            = player_y > FALL_LIMIT;
   assign game_state      = state;
   assign player_frame_en = startOfFrame & (state == PLAYING);

   // NOTE: every variable gets a default before the case, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = frame_cnt;
      lives_nxt = lives;
      level_nxt = level;
      if (startOfFrame) begin
         unique case (state)
            TITLE: if (start_req) begin
               state_nxt = RESPAWN;
               lives_nxt = 2'(START_LIVES);
               level_nxt = 2'd0;
            end
            PLAYING: begin
`ifdef KONG_GOD_MODE_EN
               if (fall)          state_nxt = RESPAWN;
               else if (goal_hit) state_nxt = LEVEL_CLEAR;
`else
               // Death outranks reaching the goal in the same frame.
               if (enemy_hit || fall) begin
                  state_nxt = DYING;
                  lives_nxt = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
               end else if (goal_hit) begin
                  state_nxt = LEVEL_CLEAR;
               end
`endif
            end
            DYING:
               if (frame_cnt == 8'(DEATH_FRAMES - 1))
                  state_nxt = (lives == 2'd0) ? GAME_OVER : RESPAWN;
               else
                  cnt_nxt = frame_cnt + 8'd1;
            RESPAWN: state_nxt = PLAYING;
            LEVEL_CLEAR:
               if (frame_cnt == 8'(CLEAR_FRAMES - 1)) begin
                  state_nxt = RESPAWN;
                  level_nxt = (level == 2'(NUM_LEVELS - 1)) ? 2'd0 : level + 2'd1;
               end else begin
                  cnt_nxt = frame_cnt + 8'd1;
               end
            GAME_OVER:
               if (start_req || frame_cnt == 8'(OVER_FRAMES - 1))
                  state_nxt = TITLE;
               else
                  cnt_nxt = frame_cnt + 8'd1;
            default: state_nxt = TITLE;
         endcase
         if (state_nxt != state) cnt_nxt = 8'd0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= TITLE;
         frame_cnt     <= 8'd0;
         lives         <= 2'd0;
         level         <= 2'd0;
         enemy_hit     <= 1'b0;
         goal_hit      <= 1'b0;
         start_req     <= 1'b0;
         player_resetN <= 1'b0;
         show_player   <= 1'b0;
      end else begin
         state     <= state_nxt;
         frame_cnt <= cnt_nxt;
         lives     <= lives_nxt;
         level     <= level_nxt;
         // On SOF the latch restarts from this cycle's input so nothing is lost between frames.
         enemy_hit <= startOfFrame ? collision_enemy : (enemy_hit | collision_enemy);
         goal_hit  <= startOfFrame ? collision_goal  : (goal_hit  | collision_goal);
         start_req <= startOfFrame ? ask_start       : (start_req | ask_start);
         player_resetN <= !(state_nxt inside {TITLE, RESPAWN, GAME_OVER});
         unique case (state_nxt)
            TITLE, GAME_OVER: show_player <= 1'b0;
            DYING:            show_player <= ~cnt_nxt[BLINK_LOG2];
            default:          show_player <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_kong_game_sequencer.sv
// Directed bench for kong_game_sequencer; expected outputs queue in a scoreboard and are checked after each frame.
module tb_kong_game_sequencer;

   localparam int FRAME_LEN = 8;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               startOfFrame = 1'b0;
   logic               ask_start = 1'b0;
   logic               collision_enemy = 1'b0;
   logic               collision_goal = 1'b0;
   logic signed [10:0] player_y = 11'sd100;
   logic               player_frame_en;
   logic               player_resetN;
   logic               show_player;
   logic [2:0]         game_state;
   logic [1:0]         lives;
   logic [1:0]         level;

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] lv;
      logic [1:0] lvl;
      logic       rn;
      logic       sh;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   kong_game_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .startOfFrame   (startOfFrame),
      .ask_start      (ask_start),
      .collision_enemy(collision_enemy),
      .collision_goal (collision_goal),
      .player_y       (player_y),
      .player_frame_en(player_frame_en),
      .player_resetN  (player_resetN),
      .show_player    (show_player),
      .game_state     (game_state),
      .lives          (lives),
      .level          (level)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input int st, input int lv, input int lvl, input bit rn, input bit sh);
      exp_t e;
      e.st  = 3'(st);
      e.lv  = 2'(lv);
      e.lvl = 2'(lvl);
      e.rn  = rn;
      e.sh  = sh;
      sb.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 8'd1, 8'd0);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_state"}, 8'(game_state), 8'(e.st));
      chk({tag, "_lives"}, 8'(lives), 8'(e.lv));
      chk({tag, "_level"}, 8'(level), 8'(e.lvl));
      chk({tag, "_resetN"}, 8'(player_resetN), 8'(e.rn));
      chk({tag, "_show"}, 8'(show_player), 8'(e.sh));
   endtask

   // One frame: optional pulses at cycle 2, optional enemy on the SOF cycle itself.
   task automatic frame(input bit e_mid, input bit g_mid, input bit s_mid, input bit e_sof,
                        input logic signed [10:0] y, input bit pfe);
      player_y = y;
      for (int c = 0; c < FRAME_LEN - 1; c++) begin
         collision_enemy = e_mid && (c == 2);
         collision_goal  = g_mid && (c == 2);
         ask_start       = s_mid && (c == 2);
         @(negedge clk);
      end
      collision_enemy = e_sof;
      collision_goal  = 1'b0;
      ask_start       = 1'b0;
      startOfFrame    = 1'b1;
      #1;
      chk("frame_en", 8'(player_frame_en), 8'(pfe));
      @(negedge clk);
      startOfFrame    = 1'b0;
      collision_enemy = 1'b0;
   endtask

   task automatic step(input string tag, input bit e, input bit g, input bit s, input bit esof,
                       input logic signed [10:0] y, input bit pfe,
                       input int st, input int lv, input int lvl, input bit rn, input bit sh);
      push_exp(st, lv, lvl, rn, sh);
      frame(e, g, s, esof, y, pfe);
      pop_check(tag);
   endtask

   // Full DYING sequence: blink pattern, then exit to RESPAWN or GAME_OVER.
   task automatic dying(input int lv, input int lvl, input bit to_over);
      for (int i = 1; i < 60; i++)
         step("dying", 0, 0, 0, 0, 11'sd100, 0, 2, lv, lvl, 1, ((i >> 3) & 1) == 0);
      if (to_over) step("die_over", 0, 0, 0, 0, 11'sd100, 0, 5, lv, lvl, 0, 0);
      else         step("die_resp", 0, 0, 0, 0, 11'sd100, 0, 3, lv, lvl, 0, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      push_exp(0, 0, 0, 0, 0);
      pop_check("reset");

      step("start",   0, 0, 1, 0, 11'sd100, 0, 3, 3, 0, 0, 1);
      step("respawn", 0, 0, 0, 0, 11'sd100, 0, 1, 3, 0, 1, 1);
      step("play",    0, 0, 0, 0, 11'sd100, 1, 1, 3, 0, 1, 1);
      step("y_edge",  0, 0, 0, 0, 11'sd470, 1, 1, 3, 0, 1, 1);
      step("y_neg",   0, 0, 0, 0, -11'sd5,  1, 1, 3, 0, 1, 1);
      step("enemy",   1, 0, 0, 0, 11'sd100, 1, 2, 2, 0, 1, 1);
      dying(2, 0, 0);
      step("back",    0, 0, 0, 0, 11'sd100, 0, 1, 2, 0, 1, 1);

      step("both",    1, 1, 0, 0, 11'sd100, 1, 2, 1, 0, 1, 1);
      dying(1, 0, 0);
      step("back2",   0, 0, 0, 0, 11'sd100, 0, 1, 1, 0, 1, 1);

      for (int k = 0; k < 4; k++) begin
         step("goal", 0, 1, 0, 0, 11'sd100, 1, 4, 1, k, 1, 1);
         for (int i = 1; i < 90; i++)
            step("clear", 0, 0, 0, 0, 11'sd100, 0, 4, 1, k, 1, 1);
         step("clear_end", 0, 0, 0, 0, 11'sd100, 0, 3, 1, (k + 1) % 4, 0, 1);
         step("resp_lvl",  0, 0, 0, 0, 11'sd100, 0, 1, 1, (k + 1) % 4, 1, 1);
      end

      step("sof_enemy",  0, 0, 0, 1, 11'sd100, 1, 1, 1, 0, 1, 1);
      step("late_death", 0, 0, 0, 0, 11'sd100, 1, 2, 0, 0, 1, 1);
      dying(0, 0, 1);
      for (int i = 1; i < 10; i++)
         step("over", 0, 0, 0, 0, 11'sd100, 0, 5, 0, 0, 0, 0);
      step("over_start", 0, 0, 1, 0, 11'sd100, 0, 0, 0, 0, 0, 0);

      step("start2",   0, 0, 1, 0, 11'sd100, 0, 3, 3, 0, 0, 1);
      step("resp2",    0, 0, 0, 0, 11'sd100, 0, 1, 3, 0, 1, 1);
      step("fall",     0, 0, 0, 0, 11'sd471, 1, 2, 2, 0, 1, 1);
      dying(2, 0, 0);
      step("back3",    0, 0, 0, 0, 11'sd100, 0, 1, 2, 0, 1, 1);
      step("enemy3",   1, 0, 0, 0, 11'sd100, 1, 2, 1, 0, 1, 1);
      dying(1, 0, 0);
      step("back4",    0, 0, 0, 0, 11'sd100, 0, 1, 1, 0, 1, 1);
      step("enemy4",   1, 0, 0, 0, 11'sd100, 1, 2, 0, 0, 1, 1);
      dying(0, 0, 1);
      for (int i = 1; i < 180; i++)
         step("over_wait", 0, 0, 0, 0, 11'sd100, 0, 5, 0, 0, 0, 0);
      step("over_timeout", 0, 0, 0, 0, 11'sd100, 0, 0, 0, 0, 0, 0);

      step("start3", 0, 0, 1, 0, 11'sd100, 0, 3, 3, 0, 0, 1);
      step("resp3",  0, 0, 0, 0, 11'sd100, 0, 1, 3, 0, 1, 1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      push_exp(0, 0, 0, 0, 0);
      pop_check("mid_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
